kernel_nios2_qsys_0_jtag_debug_cmd_sync: RTL and testbench

KERNEL_NIOS2_QSYS_0_JTAG_DEBUG_CMD_SYNC -- requirements
Module: kernel_nios2_qsys_0_jtag_debug_cmd_sync

---
 rtl/kernel_nios2_qsys_0_jtag_debug_cmd_sync.sv | 170 +++++++++++++++++
 tb/tb_kernel_nios2_qsys_0_jtag_debug_cmd_sync.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_nios2_qsys_0_jtag_debug_cmd_sync.sv
// JTAG debug command synchronizer: moves update-DR/IR toggle events into the clk domain and
// issues one action pulse per captured command. Optional parity check: KERNEL_JTAG_CMD_PARITY_EN.
`timescale 1ns/1ps

module kernel_nios2_qsys_0_jtag_debug_cmd_sync #(
    parameter  int SR_W        = 38,
    parameter  int IR_W        = 2,
    parameter  int SYNC_STAGES = 2,
    localparam int NUM_CH      = 2**IR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs_udr_tgl,
    input  logic              vs_uir_tgl,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [SR_W-1:0]   sr,
    input  logic              cmd_ready,
    output logic [SR_W-1:0]   jdo,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic              cmd_pending,
    output logic              overrun,
    output logic              parity_err
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic                   udr_hist_q, udr_hist_d;
    logic                   uir_hist_q, uir_hist_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic                   armed;
    logic                   udr_edge;
    logic                   uir_edge;

    state_t                 state_q, state_d;
    logic [SR_W-1:0]        jdo_q, jdo_d;
    logic [IR_W-1:0]        cmd_ir_q, cmd_ir_d;
    logic [NUM_CH-1:0]      take_action_q, take_action_d;
    logic [NUM_CH-1:0]      take_no_action_q, take_no_action_d;
    logic                   overrun_q, overrun_d;
`ifdef KERNEL_JTAG_CMD_PARITY_EN
    logic                   parity_err_q, parity_err_d;
`endif

    // Edge detection stays disarmed until the history flop holds a real sampled level,
    // so a toggle input parked high through reset cannot fake an event on release.
    assign armed = (arm_cnt_q == ARM_DONE);

    // NOTE: every signal written in an always_comb gets a default first; a path that
    // leaves one unassigned infers a latch.
    always_comb begin
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr_tgl};
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir_tgl};
        udr_hist_d = udr_sync_q[SYNC_STAGES-1];
        uir_hist_d = uir_sync_q[SYNC_STAGES-1];
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
        udr_edge   = armed && (udr_sync_q[SYNC_STAGES-1] != udr_hist_q);
        uir_edge   = armed && (uir_sync_q[SYNC_STAGES-1] != uir_hist_q);
    end

    always_comb begin
        state_d          = state_q;
        jdo_d            = jdo_q;
        cmd_ir_d         = cmd_ir_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        overrun_d        = overrun_q;
`ifdef KERNEL_JTAG_CMD_PARITY_EN
        parity_err_d     = parity_err_q;
`endif

        // Clears are applied first so a same-cycle set below takes priority.
        if (uir_edge) begin
            overrun_d = 1'b0;
`ifdef KERNEL_JTAG_CMD_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                if (udr_edge) begin
`ifdef KERNEL_JTAG_CMD_PARITY_EN
                    if (^sr) begin
                        parity_err_d = 1'b1;
                    end else begin
                        jdo_d    = sr;
                        cmd_ir_d = ir_in;
                        state_d  = PEND;
                    end
`else
                    jdo_d    = sr;
                    cmd_ir_d = ir_in;
                    state_d  = PEND;
`endif
                end
            end
            PEND: begin
                if (udr_edge) begin
                    overrun_d = 1'b1;
                end
                if (cmd_ready) begin
                    if (jdo_q[SR_W-1]) begin
                        take_action_d[cmd_ir_q] = 1'b1;
                    end else begin
                        take_no_action_d[cmd_ir_q] = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_q       <= '0;
            uir_sync_q       <= '0;
            udr_hist_q       <= 1'b0;
            uir_hist_q       <= 1'b0;
            arm_cnt_q        <= '0;
            state_q          <= IDLE;
            jdo_q            <= '0;
            cmd_ir_q         <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overrun_q        <= 1'b0;
        end else begin
            udr_sync_q       <= udr_sync_d;
            uir_sync_q       <= uir_sync_d;
            udr_hist_q       <= udr_hist_d;
            uir_hist_q       <= uir_hist_d;
            arm_cnt_q        <= arm_cnt_d;
            state_q          <= state_d;
            jdo_q            <= jdo_d;
            cmd_ir_q         <= cmd_ir_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            overrun_q        <= overrun_d;
        end
    end

`ifdef KERNEL_JTAG_CMD_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign jdo            = jdo_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign cmd_pending    = (state_q == PEND);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_kernel_nios2_qsys_0_jtag_debug_cmd_sync.sv
// Directed bench for kernel_nios2_qsys_0_jtag_debug_cmd_sync: default instance plus a
// SYNC_STAGES=3 / IR_W=3 instance. Inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_kernel_nios2_qsys_0_jtag_debug_cmd_sync;

`ifdef KERNEL_JTAG_CMD_PARITY_EN
    // 38'h20_0000_0003 carries three set bits, so an even-parity MSB=1 vector is used instead.
    localparam logic [37:0] SR_A = 38'h20_0000_0007;
`else
    localparam logic [37:0] SR_A = 38'h20_0000_0003;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        udr, uir, rdy;
    logic [1:0]  ir;
    logic [37:0] sr;
    logic [37:0] jdo;
    logic [3:0]  ta, tna;
    logic        pend, ovr, perr;

    logic        udr3, uir3, rdy3;
    logic [2:0]  ir3;
    logic [37:0] sr3;
    logic [37:0] jdo3;
    logic [7:0]  ta3, tna3;
    logic        pend3, ovr3, perr3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kernel_nios2_qsys_0_jtag_debug_cmd_sync dut (
        .clk(clk), .reset_n(reset_n), .vs_udr_tgl(udr), .vs_uir_tgl(uir),
        .ir_in(ir), .sr(sr), .cmd_ready(rdy), .jdo(jdo), .take_action(ta),
        .take_no_action(tna), .cmd_pending(pend), .overrun(ovr), .parity_err(perr)
    );

    kernel_nios2_qsys_0_jtag_debug_cmd_sync #(.SR_W(38), .IR_W(3), .SYNC_STAGES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .vs_udr_tgl(udr3), .vs_uir_tgl(uir3),
        .ir_in(ir3), .sr(sr3), .cmd_ready(rdy3), .jdo(jdo3), .take_action(ta3),
        .take_no_action(tna3), .cmd_pending(pend3), .overrun(ovr3), .parity_err(perr3)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        // NOTE: stimulus is driven with blocking assignments on the falling edge, well
        // clear of the rising edge the DUT samples on.
        reset_n = 1'b0;
        udr = 1'b0; uir = 1'b0; rdy = 1'b0; ir = '0; sr = '0;
        udr3 = 1'b0; uir3 = 1'b0; rdy3 = 1'b0; ir3 = '0; sr3 = '0;
        tick(2);
        checks++;
        if ({jdo, ta, tna, pend, ovr, perr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got jdo=%h ta=%b tna=%b pend=%b ovr=%b perr=%b want all 0",
                     jdo, ta, tna, pend, ovr, perr);
        end
        reset_n = 1'b1;
        tick(6);
        checks++;
        if ({ta, tna, pend} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got ta=%b tna=%b pend=%b want 0", ta, tna, pend);
        end
    endtask

    task automatic test_action;
        rdy = 1'b1; ir = 2'd2; sr = SR_A;
        udr = ~udr;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            checks++;
            if (ta !== ((k == 4) ? 4'b0100 : 4'b0000) || tna !== 4'b0000) begin
                errors++;
                $display("FAIL action_pulse edge=%0d got ta=%b tna=%b want ta=%b tna=0000",
                         k, ta, tna, (k == 4) ? 4'b0100 : 4'b0000);
            end
            if (k == 3) begin
                checks++;
                if (jdo !== SR_A || pend !== 1'b1) begin
                    errors++;
                    $display("FAIL action_capture got jdo=%h pend=%b want jdo=%h pend=1", jdo, pend, SR_A);
                end
            end
            if (k == 4) begin
                checks++;
                if (pend !== 1'b0) begin
                    errors++;
                    $display("FAIL action_pend_clear got %b want 0", pend);
                end
            end
        end
    endtask

    task automatic test_hold;
        rdy = 1'b0; ir = 2'd1; sr = 38'h05;
        udr = ~udr;
        tick(3);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (pend !== 1'b1 || ta !== 4'b0000 || tna !== 4'b0000 || jdo !== 38'h05) begin
                errors++;
                $display("FAIL hold_pending cycle=%0d got pend=%b ta=%b tna=%b jdo=%h want pend=1 no pulse jdo=05",
                         i, pend, ta, tna, jdo);
            end
            tick(1);
        end
        rdy = 1'b1;
        tick(1);
        checks++;
        if (tna !== 4'b0010 || ta !== 4'b0000 || pend !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got tna=%b ta=%b pend=%b want tna=0010 ta=0000 pend=0", tna, ta, pend);
        end
        tick(1);
        checks++;
        if (tna !== 4'b0000) begin
            errors++;
            $display("FAIL hold_single_cycle got tna=%b want 0000", tna);
        end
    endtask

    task automatic test_overrun;
        rdy = 1'b0; ir = 2'd3; sr = SR_A;
        udr = ~udr;
        tick(8);
        sr = 38'h0F;
        udr = ~udr;
        tick(5);
        checks++;
        if (ovr !== 1'b1 || jdo !== SR_A || pend !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got ovr=%b jdo=%h pend=%b want ovr=1 jdo=%h pend=1", ovr, jdo, pend, SR_A);
        end
        uir = ~uir;
        tick(4);
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got %b want 0", ovr);
        end
        // Drop and clear landing on the same edge: the drop must win.
        udr = ~udr; uir = ~uir;
        tick(4);
        checks++;
        if (ovr !== 1'b1 || jdo !== SR_A) begin
            errors++;
            $display("FAIL overrun_set_wins got ovr=%b jdo=%h want ovr=1 jdo=%h", ovr, jdo, SR_A);
        end
        uir = ~uir;
        tick(4);
        rdy = 1'b1;
        tick(1);
        checks++;
        if (ta !== 4'b1000 || tna !== 4'b0000 || ovr !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drain got ta=%b tna=%b ovr=%b want ta=1000 tna=0000 ovr=0", ta, tna, ovr);
        end
        tick(2);
    endtask

    task automatic test_parity;
        int pulses = 0;
        rdy = 1'b1; ir = 2'd0; sr = 38'h1;
        udr = ~udr;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if ((ta | tna) != 4'b0000) pulses++;
`ifndef KERNEL_JTAG_CMD_PARITY_EN
            if (k == 4) begin
                checks++;
                if (tna !== 4'b0001 || ta !== 4'b0000) begin
                    errors++;
                    $display("FAIL parity_off_pulse got ta=%b tna=%b want ta=0000 tna=0001", ta, tna);
                end
            end
`endif
        end
`ifdef KERNEL_JTAG_CMD_PARITY_EN
        checks++;
        if (perr !== 1'b1 || pulses != 0 || jdo !== SR_A || pend !== 1'b0) begin
            errors++;
            $display("FAIL parity_reject got perr=%b pulses=%0d jdo=%h pend=%b want perr=1 pulses=0 jdo=%h pend=0",
                     perr, pulses, jdo, pend, SR_A);
        end
        uir = ~uir;
        tick(4);
        checks++;
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL parity_clear got %b want 0", perr);
        end
`else
        checks++;
        if (perr !== 1'b0 || pulses != 1 || jdo !== 38'h1) begin
            errors++;
            $display("FAIL parity_off_accept got perr=%b pulses=%0d jdo=%h want perr=0 pulses=1 jdo=1",
                     perr, pulses, jdo);
        end
`endif
    endtask

    task automatic test_reset_pending;
        int pulses = 0;
        rdy = 1'b0; ir = 2'd2; sr = SR_A;
        udr = ~udr;
        tick(4);
        checks++;
        if (pend !== 1'b1) begin
            errors++;
            $display("FAIL rst_pend_setup got %b want 1", pend);
        end
        udr = ~udr;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({jdo, ta, tna, pend, ovr, perr} !== '0) begin
            errors++;
            $display("FAIL rst_async got jdo=%h ta=%b tna=%b pend=%b ovr=%b perr=%b want all 0",
                     jdo, ta, tna, pend, ovr, perr);
        end
        tick(2);
        udr = ~udr;
        rdy = 1'b1;
        tick(1);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if ((ta | tna) != 4'b0000 || pend !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rst_no_pulse got %0d active cycles want 0", pulses);
        end
    endtask

    task automatic test_wide;
        rdy3 = 1'b1; ir3 = 3'd7; sr3 = SR_A;
        udr3 = ~udr3;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            checks++;
            if (ta3 !== ((k == 5) ? 8'h80 : 8'h00) || tna3 !== 8'h00) begin
                errors++;
                $display("FAIL wide_pulse edge=%0d got ta=%b tna=%b want ta=%b tna=00000000",
                         k, ta3, tna3, (k == 5) ? 8'h80 : 8'h00);
            end
            if (k == 4) begin
                checks++;
                if (jdo3 !== SR_A || pend3 !== 1'b1) begin
                    errors++;
                    $display("FAIL wide_capture got jdo=%h pend=%b want jdo=%h pend=1", jdo3, pend3, SR_A);
                end
            end
        end
        checks++;
        if (pend3 !== 1'b0 || ovr3 !== 1'b0 || perr3 !== 1'b0) begin
            errors++;
            $display("FAIL wide_idle got pend=%b ovr=%b perr=%b want 0", pend3, ovr3, perr3);
        end
        uir3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_action();
        test_hold();
        test_overrun();
        test_parity();
        test_reset_pending();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
